rx_port_read_requester: RTL and testbench
=========================================

# rx_port_read_requester

Issues host read requests for one scatter-gather element on the receive side of a RIFFA channel. This is the read-direction counterpart of the transmit-side writer. It splits a (address, length) element into PCIe-legal read requests bounded by the max read request size and 4 KB address boundaries. It issues each request only when the receive buffer has room for all of its completion data. It sits between the rx_port scatter-gather reader and the rx engine request interface.

## Interface
- C_FIFO_WORDS, 2048: receive buffer capacity in 32-bit words; power of two, ≥1024.
- C_FIFO_WORDS_WIDTH, clog2(C_FIFO_WORDS+1): width of the credit counter and credit return bus.
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high; clock CLK.
- CONFIG_MAX_READ_REQUEST_SIZE  in  3  000=128B, 001=256B, 010=512B, 011=1KB, 100=2KB, 101+=4KB.
- XFER_START  in  1  element valid; held until XFER_ACK.
- XFER_ADDR  in  64  element byte address; bits [1:0] are ignored and treated as 0.
- XFER_LEN  in  32  element length in 32-bit words.
- XFER_ACK  out  1  one-cycle pulse; element captured.
- XFER_DONE  out  1  one-cycle pulse; last request of the element accepted.
- ABORT  in  1  cancels the element in progress.
- CREDIT_VALID  in  1  buffer words freed this cycle.
- CREDIT_WORDS  in  C_FIFO_WORDS_WIDTH  number of words freed.
- RX_REQ  out  1  read request valid.
- RX_REQ_ACK  in  1  request accepted by the rx engine.
- RX_ADDR  out  64  request byte address.
- RX_LEN  out  10  request length in words; 0 encodes 1024.
- BUSY  out  1  FSM is not in IDLE.

## Operation
- States: IDLE, CALC, WAIT_CREDIT, REQ, DONE.
- IDLE:
  - XFER_START=1 → capture rAddr = {XFER_ADDR[63:2], 2'b00} and rRemain = XFER_LEN.
  - Pulse XFER_ACK and go to CALC.
- CALC (one cycle): rLen = min(rRemain, maxWords, boundWords).
  - maxWords = 32 << CONFIG_MAX_READ_REQUEST_SIZE, capped at 1024.
  - boundWords = (4096 − rAddr[11:0]) >> 2.
  - rRemain = 0 → DONE; otherwise → WAIT_CREDIT.
- WAIT_CREDIT: when rSpace ≥ rLen → REQ.
- REQ:
  - RX_REQ=1, with RX_ADDR and RX_LEN stable until RX_REQ_ACK.
  - On RX_REQ_ACK: rAddr += rLen·4, rRemain −= rLen, rSpace −= rLen, then → CALC.
- DONE: pulse XFER_DONE, then → IDLE.
- Credit counter rSpace:
  - Reset value is C_FIFO_WORDS.
  - On CREDIT_VALID, add CREDIT_WORDS, saturating at C_FIFO_WORDS.
  - A debit (request accept) and a credit in the same cycle both apply, as net = rSpace − debit + credit.
  - ABORT and element completion do not touch rSpace, because completions for outstanding requests still arrive.
- ABORT:
  - Any state other than IDLE → IDLE at the next edge; RX_REQ is deasserted the following cycle.
  - No XFER_DONE is issued.
  - If ABORT and RX_REQ_ACK coincide, the acked request is debited and then the FSM aborts.
  - ABORT in IDLE has no effect.
- A zero-length element produces XFER_ACK, then XFER_DONE two cycles later, with no request.
- 64-bit address arithmetic carries across bit 32.

## Timing
- Reset values: XFER_ACK=0, XFER_DONE=0, RX_REQ=0, RX_ADDR=0, RX_LEN=0, BUSY=0; state=IDLE.
- All outputs are registered.
- XFER_START sampled in IDLE at edge n → XFER_ACK=1 and BUSY=1 during cycle n+1.
- First RX_REQ rises at n+3 if credit is available.
- RX_REQ_ACK at edge m → RX_REQ low at m+1; next RX_REQ at m+3 at the earliest.
- XFER_DONE asserts at m+3 after the final ack.
- CONFIG_MAX_READ_REQUEST_SIZE is sampled in CALC only.

## Structure
- Shared package rx_port_pkg holds:
  - the state enum;
  - constant PCIE_BOUNDARY_BYTES=4096;
  - function max_read_words(cfg).
- One sub-module, rx_req_credit_counter: the saturating add/subtract credit counter.
- Everything else lives in one file.

## Test plan
- Boundary split: MRRS=010, addr 0xF00, len 300 → three requests:
  - (0x0F00, 64), (0x1000, 128), (0x1200, 108);
  - one XFER_DONE; rSpace = 2048 − 300.
- Max size: MRRS=101, addr 0x0, len 2048, C_FIFO_WORDS=2048 → requests (0x0, RX_LEN=0), then (0x1000, RX_LEN=0); then rSpace=0.
- Credit stall:
  - fifo 1024, MRRS=101, addr 0x0, len 2048 → first 1024-word request, then RX_REQ stays low.
  - CREDIT_WORDS=512 → no request; second 512 → second request (0x1000, 1024).
- Simultaneous events: debit 128 and credit 64 in the same cycle → rSpace decreases by exactly 64. Credit beyond capacity saturates at C_FIFO_WORDS.
- ABORT mid-REQ:
  - ABORT while RX_REQ is held → RX_REQ low within 1 cycle, no XFER_DONE, rSpace unchanged.
  - A new XFER_START is then accepted normally.
- Zero length and address edges:
  - len 0 → XFER_ACK, XFER_DONE, no RX_REQ.
  - addr 0x0000_0000_FFFF_FFF0 with len 8 → requests (0xFFFF_FFF0, 4), then (0x1_0000_0000, 4).
- RST asserted mid-transfer → all outputs return to reset values next cycle, and rSpace returns to C_FIFO_WORDS.

Source files
------------

// File: rtl/rx_port_pkg.sv
// Shared types and helpers for the rx_port read-request path.
package rx_port_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_WAIT_CREDIT,
    S_REQ,
    S_DONE
  } state_t;

  localparam int PCIE_BOUNDARY_BYTES = 4096;

  // Encoded max read request size in 32-bit words; codes 5..7 all mean 4 KB, capped at 1024 words.
  function automatic logic [10:0] max_read_words(input logic [2:0] cfg);
    if (cfg >= 3'd5) return 11'd1024;
    return 11'd32 << cfg;
  endfunction

endpackage

// File: rtl/rx_req_credit_counter.sv
// Receive-buffer space counter: net update of space - debit + credit, saturating at capacity.
// One-cycle update latency; no backpressure.
module rx_req_credit_counter #(
  parameter int C_FIFO_WORDS       = 2048,
  parameter int C_FIFO_WORDS_WIDTH = $clog2(C_FIFO_WORDS + 1)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          debit_vld,
  input  logic [C_FIFO_WORDS_WIDTH-1:0] debit_words,
  input  logic                          credit_vld,
  input  logic [C_FIFO_WORDS_WIDTH-1:0] credit_words,
  output logic [C_FIFO_WORDS_WIDTH-1:0] space
);

  localparam int W1 = C_FIFO_WORDS_WIDTH + 1;
  localparam logic [W1-1:0] CAP = W1'(C_FIFO_WORDS);

  logic [W1-1:0] debit_ext;
  logic [W1-1:0] credit_ext;
  logic [W1-1:0] raw_sum;
  logic [W1-1:0] sat_sum;

  // Debits never exceed space (requests wait for room), so the extra bit only absorbs credit overflow.
  always_comb begin
    debit_ext  = debit_vld  ? {1'b0, debit_words}  : '0;
    credit_ext = credit_vld ? {1'b0, credit_words} : '0;
    raw_sum    = {1'b0, space} - debit_ext + credit_ext;
    sat_sum    = (raw_sum > CAP) ? CAP : raw_sum;
  end

  always_ff @(posedge CLK) begin
    if (RST) space <= C_FIFO_WORDS_WIDTH'(C_FIFO_WORDS);
    else     space <= sat_sum[C_FIFO_WORDS_WIDTH-1:0];
  end

endmodule

// File: rtl/rx_port_read_requester.sv
// Splits one scatter-gather element into MRRS/4KB-bounded read requests, each issued only when buffer space covers it.
// Registered outputs; first request 3 cycles after XFER_START; RX_REQ held until RX_REQ_ACK, stalls on credit.
module rx_port_read_requester
  import rx_port_pkg::*;
#(
  parameter int C_FIFO_WORDS       = 2048,
  parameter int C_FIFO_WORDS_WIDTH = $clog2(C_FIFO_WORDS + 1)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [2:0]                    CONFIG_MAX_READ_REQUEST_SIZE,
  input  logic                          XFER_START,
  input  logic [63:0]                   XFER_ADDR,
  input  logic [31:0]                   XFER_LEN,
  output logic                          XFER_ACK,
  output logic                          XFER_DONE,
  input  logic                          ABORT,
  input  logic                          CREDIT_VALID,
  input  logic [C_FIFO_WORDS_WIDTH-1:0] CREDIT_WORDS,
  output logic                          RX_REQ,
  input  logic                          RX_REQ_ACK,
  output logic [63:0]                   RX_ADDR,
  output logic [9:0]                    RX_LEN,
  output logic                          BUSY
);

  state_t                        r_state;
  state_t                        s_next;
  logic [63:0]                   r_addr;
  logic [31:0]                   r_remain;
  logic [10:0]                   r_len;
  logic [C_FIFO_WORDS_WIDTH-1:0] r_space;
  logic [10:0]                   max_words;
  logic [10:0]                   bound_words;
  logic [10:0]                   len_calc;
  logic                          accept;

  // An ack coinciding with ABORT still counts: the engine owns that request now.
  assign accept = (r_state == S_REQ) && RX_REQ_ACK;

  always_comb begin
    max_words   = max_read_words(CONFIG_MAX_READ_REQUEST_SIZE);
    bound_words = 11'((13'(PCIE_BOUNDARY_BYTES) - {1'b0, r_addr[11:0]}) >> 2);
    len_calc    = (max_words < bound_words) ? max_words : bound_words;
    if (r_remain < {21'd0, len_calc}) len_calc = r_remain[10:0];
  end

  always_comb begin
    s_next = r_state;
    case (r_state)
      S_IDLE:        if (XFER_START) s_next = S_CALC;
      S_CALC:        s_next = (r_remain == 32'd0) ? S_DONE : S_WAIT_CREDIT;
      S_WAIT_CREDIT: if (r_space >= C_FIFO_WORDS_WIDTH'(r_len)) s_next = S_REQ;
      S_REQ:         if (RX_REQ_ACK) s_next = S_CALC;
      S_DONE:        s_next = S_IDLE;
      default:       s_next = S_IDLE;
    endcase
    if (ABORT && (r_state != S_IDLE)) s_next = S_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_remain  <= '0;
      r_len     <= '0;
      XFER_ACK  <= 1'b0;
      XFER_DONE <= 1'b0;
      RX_REQ    <= 1'b0;
      RX_ADDR   <= '0;
      RX_LEN    <= '0;
      BUSY      <= 1'b0;
    end else begin
      r_state   <= s_next;
      XFER_ACK  <= (r_state == S_IDLE) && XFER_START;
      XFER_DONE <= (r_state == S_DONE) && !ABORT;
      RX_REQ    <= (s_next == S_REQ);
      BUSY      <= (s_next != S_IDLE);
      if ((r_state == S_IDLE) && XFER_START) begin
        r_addr   <= XFER_ADDR & ~64'd3;
        r_remain <= XFER_LEN;
      end
      if (r_state == S_CALC) r_len <= len_calc;
      if ((r_state == S_WAIT_CREDIT) && (s_next == S_REQ)) begin
        RX_ADDR <= r_addr;
        RX_LEN  <= r_len[9:0];
      end
      if (accept) begin
        r_addr   <= r_addr + {51'd0, r_len, 2'b00};
        r_remain <= r_remain - {21'd0, r_len};
      end
    end
  end

  rx_req_credit_counter #(
    .C_FIFO_WORDS       (C_FIFO_WORDS),
    .C_FIFO_WORDS_WIDTH (C_FIFO_WORDS_WIDTH)
  ) u_credit (
    .CLK          (CLK),
    .RST          (RST),
    .debit_vld    (accept),
    .debit_words  (C_FIFO_WORDS_WIDTH'(r_len)),
    .credit_vld   (CREDIT_VALID),
    .credit_words (CREDIT_WORDS),
    .space        (r_space)
  );

endmodule

// File: tb/tb_rx_port_read_requester.sv
// Directed bench: instance A has a 2048-word buffer, instance B a 1024-word buffer, sharing all inputs.
module tb_rx_port_read_requester;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  cfg = 3'd0;
  logic        XFER_START = 1'b0;
  logic [63:0] XFER_ADDR = '0;
  logic [31:0] XFER_LEN = '0;
  logic        ABORT = 1'b0;
  logic        CREDIT_VALID = 1'b0;
  logic [11:0] credit_words = '0;
  logic        RX_REQ_ACK = 1'b0;

  logic        a_xfer_ack, a_xfer_done, a_rx_req, a_busy;
  logic [63:0] a_rx_addr;
  logic [9:0]  a_rx_len;
  logic        b_xfer_ack, b_xfer_done, b_rx_req, b_busy;
  logic [63:0] b_rx_addr;
  logic [9:0]  b_rx_len;

  int checks = 0;
  int errors = 0;
  logic [63:0] got_addr[$];
  logic [9:0]  got_len[$];
  int          done_cnt;

  always #5 CLK = ~CLK;

  rx_port_read_requester #(.C_FIFO_WORDS(2048)) dut_a (
    .CLK(CLK), .RST(RST), .CONFIG_MAX_READ_REQUEST_SIZE(cfg),
    .XFER_START(XFER_START), .XFER_ADDR(XFER_ADDR), .XFER_LEN(XFER_LEN),
    .XFER_ACK(a_xfer_ack), .XFER_DONE(a_xfer_done), .ABORT(ABORT),
    .CREDIT_VALID(CREDIT_VALID), .CREDIT_WORDS(credit_words),
    .RX_REQ(a_rx_req), .RX_REQ_ACK(RX_REQ_ACK), .RX_ADDR(a_rx_addr), .RX_LEN(a_rx_len),
    .BUSY(a_busy)
  );

  rx_port_read_requester #(.C_FIFO_WORDS(1024)) dut_b (
    .CLK(CLK), .RST(RST), .CONFIG_MAX_READ_REQUEST_SIZE(cfg),
    .XFER_START(XFER_START), .XFER_ADDR(XFER_ADDR), .XFER_LEN(XFER_LEN),
    .XFER_ACK(b_xfer_ack), .XFER_DONE(b_xfer_done), .ABORT(ABORT),
    .CREDIT_VALID(CREDIT_VALID), .CREDIT_WORDS(credit_words[10:0]),
    .RX_REQ(b_rx_req), .RX_REQ_ACK(RX_REQ_ACK), .RX_ADDR(b_rx_addr), .RX_LEN(b_rx_len),
    .BUSY(b_busy)
  );

  function automatic logic req_of(input bit use_b);
    return use_b ? b_rx_req : a_rx_req;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut();
    RST = 1'b1; XFER_START = 1'b0; ABORT = 1'b0; CREDIT_VALID = 1'b0; RX_REQ_ACK = 1'b0;
    tick(); tick();
    RST = 1'b0;
  endtask

  // Leaves the bench one sample after the capturing edge, where XFER_ACK is visible.
  task automatic start_xfer(input logic [63:0] a, input logic [31:0] l);
    XFER_ADDR = a; XFER_LEN = l; XFER_START = 1'b1;
    tick();
    XFER_START = 1'b0;
  endtask

  task automatic wait_req(input bit use_b, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (req_of(use_b)) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // Acks up to max_reqs requests, recording them, until XFER_DONE or budget expiry.
  task automatic serve(input bit use_b, input int max_reqs, input int budget);
    got_addr.delete(); got_len.delete(); done_cnt = 0;
    for (int c = 0; c < budget && done_cnt == 0; c++) begin
      if (req_of(use_b) && got_addr.size() < max_reqs) begin
        got_addr.push_back(use_b ? b_rx_addr : a_rx_addr);
        got_len.push_back(use_b ? b_rx_len : a_rx_len);
        RX_REQ_ACK = 1'b1;
      end
      tick();
      RX_REQ_ACK = 1'b0;
      if (use_b ? b_xfer_done : a_xfer_done) done_cnt++;
    end
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if ({a_xfer_ack, a_xfer_done, a_rx_req, a_busy} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 0000", {a_xfer_ack, a_xfer_done, a_rx_req, a_busy}); end
    checks++; if (a_rx_addr !== 64'd0) begin errors++; $display("FAIL reset_addr: got %0h want 0", a_rx_addr); end
    checks++; if (a_rx_len !== 10'd0) begin errors++; $display("FAIL reset_len: got %0d want 0", a_rx_len); end
    checks++; if (dut_a.r_space !== 12'd2048) begin errors++; $display("FAIL reset_space_a: got %0d want 2048", dut_a.r_space); end
    checks++; if (dut_b.r_space !== 11'd1024) begin errors++; $display("FAIL reset_space_b: got %0d want 1024", dut_b.r_space); end
  endtask

  task automatic test_timing();
    reset_dut(); cfg = 3'd0;
    start_xfer(64'h103, 32'd32);
    checks++; if ({a_xfer_ack, a_busy} !== 2'b11) begin errors++; $display("FAIL tim_ack_busy: got %b want 11", {a_xfer_ack, a_busy}); end
    tick();
    checks++; if ({a_xfer_ack, a_rx_req} !== 2'b00) begin errors++; $display("FAIL tim_n2: got %b want 00", {a_xfer_ack, a_rx_req}); end
    tick();
    checks++; if ({a_rx_req, a_rx_addr, a_rx_len} !== {1'b1, 64'h100, 10'd32}) begin errors++; $display("FAIL tim_req: got %b %0h %0d want 1 100 32", a_rx_req, a_rx_addr, a_rx_len); end
    RX_REQ_ACK = 1'b1; tick(); RX_REQ_ACK = 1'b0;
    checks++; if (a_rx_req !== 1'b0) begin errors++; $display("FAIL tim_req_drop: got %b want 0", a_rx_req); end
    tick();
    checks++; if (a_xfer_done !== 1'b0) begin errors++; $display("FAIL tim_done_early: got %b want 0", a_xfer_done); end
    tick();
    checks++; if ({a_xfer_done, a_busy} !== 2'b10) begin errors++; $display("FAIL tim_done: got %b want 10", {a_xfer_done, a_busy}); end
    checks++; if (dut_a.r_space !== 12'd2016) begin errors++; $display("FAIL tim_space: got %0d want 2016", dut_a.r_space); end
  endtask

  task automatic test_zero_len();
    reset_dut();
    start_xfer(64'h40, 32'd0);
    checks++; if (a_xfer_ack !== 1'b1) begin errors++; $display("FAIL zero_ack: got %b want 1", a_xfer_ack); end
    tick();
    checks++; if ({a_xfer_done, a_rx_req} !== 2'b00) begin errors++; $display("FAIL zero_n2: got %b want 00", {a_xfer_done, a_rx_req}); end
    tick();
    checks++; if ({a_xfer_done, a_rx_req} !== 2'b10) begin errors++; $display("FAIL zero_done: got %b want 10", {a_xfer_done, a_rx_req}); end
  endtask

  task automatic test_boundary_split();
    logic [63:0] ea[3];
    logic [9:0]  el[3];
    ea = '{64'h0F00, 64'h1000, 64'h1200};
    el = '{10'd64, 10'd128, 10'd108};
    reset_dut(); cfg = 3'b010;
    start_xfer(64'hF00, 32'd300);
    serve(1'b0, 8, 200);
    checks++; if (got_addr.size() !== 3) begin errors++; $display("FAIL split_count: got %0d want 3", got_addr.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_addr.size()) begin errors++; $display("FAIL split_req%0d: got none want %0h/%0d", i, ea[i], el[i]); end
      else if ({got_addr[i], got_len[i]} !== {ea[i], el[i]}) begin errors++; $display("FAIL split_req%0d: got %0h/%0d want %0h/%0d", i, got_addr[i], got_len[i], ea[i], el[i]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL split_done: got %0d want 1", done_cnt); end
    checks++; if (dut_a.r_space !== 12'd1748) begin errors++; $display("FAIL split_space: got %0d want 1748", dut_a.r_space); end
  endtask

  task automatic test_max_size();
    reset_dut(); cfg = 3'b101;
    start_xfer(64'h0, 32'd2048);
    serve(1'b0, 8, 200);
    checks++; if (got_addr.size() !== 2) begin errors++; $display("FAIL max_count: got %0d want 2", got_addr.size()); end
    else begin
      checks++; if ({got_addr[0], got_len[0]} !== {64'h0, 10'd0}) begin errors++; $display("FAIL max_req0: got %0h/%0d want 0/0", got_addr[0], got_len[0]); end
      checks++; if ({got_addr[1], got_len[1]} !== {64'h1000, 10'd0}) begin errors++; $display("FAIL max_req1: got %0h/%0d want 1000/0", got_addr[1], got_len[1]); end
    end
    checks++; if (dut_a.r_space !== 12'd0) begin errors++; $display("FAIL max_space: got %0d want 0", dut_a.r_space); end
  endtask

  task automatic test_credit_stall();
    reset_dut(); cfg = 3'b101;
    start_xfer(64'h0, 32'd2048);
    serve(1'b1, 8, 30);
    checks++; if (got_addr.size() !== 1) begin errors++; $display("FAIL stall_first: got %0d reqs want 1", got_addr.size()); end
    checks++; if ({b_rx_req, done_cnt[0]} !== 2'b00) begin errors++; $display("FAIL stall_idle: got %b want 00", {b_rx_req, done_cnt[0]}); end
    checks++; if (dut_b.r_space !== 11'd0) begin errors++; $display("FAIL stall_space0: got %0d want 0", dut_b.r_space); end
    CREDIT_VALID = 1'b1; credit_words = 12'd512; tick(); CREDIT_VALID = 1'b0;
    serve(1'b1, 8, 15);
    checks++; if (got_addr.size() !== 0) begin errors++; $display("FAIL stall_half: got %0d reqs want 0", got_addr.size()); end
    checks++; if (dut_b.r_space !== 11'd512) begin errors++; $display("FAIL stall_space512: got %0d want 512", dut_b.r_space); end
    CREDIT_VALID = 1'b1; credit_words = 12'd512; tick(); CREDIT_VALID = 1'b0;
    serve(1'b1, 8, 40);
    checks++;
    if (got_addr.size() !== 1) begin errors++; $display("FAIL stall_second: got %0d reqs want 1", got_addr.size()); end
    else if ({got_addr[0], got_len[0]} !== {64'h1000, 10'd0}) begin errors++; $display("FAIL stall_second: got %0h/%0d want 1000/0", got_addr[0], got_len[0]); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stall_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    reset_dut(); cfg = 3'b010;
    start_xfer(64'h0, 32'd256);
    wait_req(1'b0, 20, ok);
    RX_REQ_ACK = 1'b1; tick(); RX_REQ_ACK = 1'b0;
    checks++; if (!ok || dut_a.r_space !== 12'd1920) begin errors++; $display("FAIL sim_first: got ok=%b space=%0d want 1 1920", ok, dut_a.r_space); end
    wait_req(1'b0, 20, ok);
    RX_REQ_ACK = 1'b1; CREDIT_VALID = 1'b1; credit_words = 12'd64;
    tick(); RX_REQ_ACK = 1'b0; CREDIT_VALID = 1'b0;
    checks++; if (!ok || dut_a.r_space !== 12'd1856) begin errors++; $display("FAIL sim_net: got ok=%b space=%0d want 1 1856", ok, dut_a.r_space); end
    CREDIT_VALID = 1'b1; credit_words = 12'd1000; tick(); CREDIT_VALID = 1'b0;
    checks++; if (dut_a.r_space !== 12'd2048) begin errors++; $display("FAIL sim_sat: got %0d want 2048", dut_a.r_space); end
  endtask

  task automatic test_abort();
    bit ok;
    int dn;
    reset_dut(); cfg = 3'd0;
    start_xfer(64'h0, 32'd64);
    wait_req(1'b0, 20, ok);
    tick(); tick();
    checks++; if ({ok, a_rx_req, a_rx_addr, a_rx_len} !== {2'b11, 64'h0, 10'd32}) begin errors++; $display("FAIL abort_hold: got %b%b %0h %0d want 11 0 32", ok, a_rx_req, a_rx_addr, a_rx_len); end
    ABORT = 1'b1; tick(); ABORT = 1'b0;
    checks++; if ({a_rx_req, a_busy} !== 2'b00) begin errors++; $display("FAIL abort_drop: got %b want 00", {a_rx_req, a_busy}); end
    dn = 0;
    for (int c = 0; c < 6; c++) begin tick(); if (a_xfer_done) dn++; end
    checks++; if (dn !== 0) begin errors++; $display("FAIL abort_nodone: got %0d want 0", dn); end
    checks++; if (dut_a.r_space !== 12'd2048) begin errors++; $display("FAIL abort_space: got %0d want 2048", dut_a.r_space); end
    start_xfer(64'h400, 32'd64);
    wait_req(1'b0, 20, ok);
    RX_REQ_ACK = 1'b1; ABORT = 1'b1; tick(); RX_REQ_ACK = 1'b0; ABORT = 1'b0;
    checks++; if ({ok, a_rx_req, a_busy} !== 3'b100 || dut_a.r_space !== 12'd2016) begin errors++; $display("FAIL abort_ack: got %b space=%0d want 100 2016", {ok, a_rx_req, a_busy}, dut_a.r_space); end
    start_xfer(64'h2000, 32'd16);
    serve(1'b0, 4, 50);
    checks++;
    if (got_addr.size() !== 1) begin errors++; $display("FAIL abort_restart: got %0d reqs want 1", got_addr.size()); end
    else if ({got_addr[0], got_len[0]} !== {64'h2000, 10'd16}) begin errors++; $display("FAIL abort_restart: got %0h/%0d want 2000/16", got_addr[0], got_len[0]); end
    checks++; if (done_cnt !== 1 || dut_a.r_space !== 12'd2000) begin errors++; $display("FAIL abort_restart_end: got done=%0d space=%0d want 1 2000", done_cnt, dut_a.r_space); end
  endtask

  task automatic test_addr_carry();
    reset_dut(); cfg = 3'd0;
    start_xfer(64'h0000_0000_FFFF_FFF0, 32'd8);
    serve(1'b0, 8, 60);
    checks++; if (got_addr.size() !== 2) begin errors++; $display("FAIL carry_count: got %0d want 2", got_addr.size()); end
    else begin
      checks++; if ({got_addr[0], got_len[0]} !== {64'hFFFF_FFF0, 10'd4}) begin errors++; $display("FAIL carry_req0: got %0h/%0d want ffff_fff0/4", got_addr[0], got_len[0]); end
      checks++; if ({got_addr[1], got_len[1]} !== {64'h1_0000_0000, 10'd4}) begin errors++; $display("FAIL carry_req1: got %0h/%0d want 1_0000_0000/4", got_addr[1], got_len[1]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL carry_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_rst_mid();
    bit ok;
    reset_dut(); cfg = 3'd0;
    start_xfer(64'h0, 32'd2048);
    serve(1'b0, 1, 20);
    wait_req(1'b0, 20, ok);
    checks++; if (!ok || dut_a.r_space !== 12'd2016) begin errors++; $display("FAIL rst_pre: got ok=%b space=%0d want 1 2016", ok, dut_a.r_space); end
    RST = 1'b1; tick();
    checks++; if ({a_xfer_ack, a_xfer_done, a_rx_req, a_busy, a_rx_addr, a_rx_len} !== 78'd0) begin errors++; $display("FAIL rst_outputs: got %b %0h %0d want 0", {a_xfer_ack, a_xfer_done, a_rx_req, a_busy}, a_rx_addr, a_rx_len); end
    checks++; if (dut_a.r_space !== 12'd2048) begin errors++; $display("FAIL rst_space: got %0d want 2048", dut_a.r_space); end
    RST = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_timing();
    test_zero_len();
    test_boundary_split();
    test_max_size();
    test_credit_stall();
    test_simultaneous();
    test_abort();
    test_addr_carry();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
